// File: rtl/mul_pkg.sv
// Shared definitions for the Karatsuba multiplier family: FSM state encoding and the
// fixed start-to-done latency that parent blocks and benches can rely on.
package mul_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMulZ0,
    StMulZ2,
    StMulZ1,
    StCombine,
    StDone
  } kmul_state_e;

  // Cycles from the accepting edge to the edge that enters DONE.
  function automatic int unsigned kmul_latency(input int unsigned width);
    return 2 + 3 * (width / 2 + 2);
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-add multiplier: N iterations per Start pulse (the Start edge
// itself handles bit 0), then a one-cycle Done pulse with P valid and held afterwards.
module shift_add_mul #(
  parameter int unsigned N = 9
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] P,
  output logic           Done
);

  localparam int unsigned CntW = $clog2(N + 1);

  logic [N-1:0]   a_sh_q;
  logic [2*N-1:0] b_sh_q;
  logic [2*N-1:0] acc_q;
  logic [CntW-1:0] cnt_q;
  logic           busy_q;
  logic           done_q;
  logic [2*N-1:0] b_ext;

  assign b_ext = {{N{1'b0}}, B};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (Start) begin
        acc_q  <= A[0] ? b_ext : '0;
        a_sh_q <= A >> 1;
        b_sh_q <= b_ext << 1;
        cnt_q  <= CntW'(N - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (a_sh_q[0]) begin
          acc_q <= acc_q + b_sh_q;
        end
        a_sh_q <= a_sh_q >> 1;
        b_sh_q <= b_sh_q << 1;
        cnt_q  <= cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign P    = acc_q;
  assign Done = done_q;

endmodule

// File: rtl/karatsuba_multiplier.sv
// Sequential Karatsuba multiplier: three partial products on one time-shared shift-add
// unit, sign-magnitude handling around an unsigned core, fixed operand-independent latency.
module karatsuba_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter bit          SIGNED = 1'b1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Multiplier,
  input  logic [WIDTH-1:0]   Multiplicand,
  output logic [2*WIDTH-1:0] Product,
  output logic               Done,
  output logic               Busy
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned N  = H + 1;
  localparam int unsigned PW = 2 * N;
  localparam int unsigned MW = 2 * WIDTH + 2;

  kmul_state_e state_q, state_d;

  logic [WIDTH-1:0]   a_q, b_q;
  logic               sign_q;
  logic [H-1:0]       alo_q, ahi_q, blo_q, bhi_q;
  logic [H:0]         sx_q, sy_q;
  logic [PW-1:0]      z0_q, z2_q;
  logic [2*WIDTH-1:0] product_q;
  logic               launch_q;

  logic [N-1:0]       sub_a, sub_b;
  logic               sub_start;
  logic [PW-1:0]      sub_p;
  logic               sub_done;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [PW-1:0]      z1;
  logic [MW-1:0]      mag_wide;
  logic [2*WIDTH-1:0] mag, result;

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (Start) state_d = StLoad;
      StLoad:    state_d = StMulZ0;
      StMulZ0:   if (sub_done) state_d = StMulZ2;
      StMulZ2:   if (sub_done) state_d = StMulZ1;
      StMulZ1:   if (sub_done) state_d = StCombine;
      StCombine: state_d = StDone;
      StDone:    if (!Start) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output / sub-multiplier steering
  always_comb begin
    sub_a = '0;
    sub_b = '0;
    case (state_q)
      StMulZ0: begin
        sub_a = {1'b0, alo_q};
        sub_b = {1'b0, blo_q};
      end
      StMulZ2: begin
        sub_a = {1'b0, ahi_q};
        sub_b = {1'b0, bhi_q};
      end
      StMulZ1: begin
        sub_a = sx_q;
        sub_b = sy_q;
      end
      default: ;
    endcase
    sub_start = launch_q;
    Busy      = (state_q != StIdle) && (state_q != StDone);
    Done      = (state_q == StDone);
  end

  // Launch pulse on the first cycle of each MUL phase.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      launch_q <= 1'b0;
    end else begin
      launch_q <= (state_d != state_q) &&
                  ((state_d == StMulZ0) || (state_d == StMulZ2) || (state_d == StMulZ1));
    end
  end

  // Magnitudes: two's-complement negation maps the most negative value onto 2^(W-1).
  always_comb begin
    mag_a = (SIGNED && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b = (SIGNED && b_q[WIDTH-1]) ? -b_q : b_q;
  end

  // Recombination; p1 is still held at the sub-multiplier output during COMBINE.
  always_comb begin
    z1       = sub_p - z2_q - z0_q;
    mag_wide = (MW'(z2_q) << WIDTH) + (MW'(z1) << H) + MW'(z0_q);
    mag      = mag_wide[2*WIDTH-1:0];
    result   = sign_q ? -mag : mag;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      alo_q     <= '0;
      ahi_q     <= '0;
      blo_q     <= '0;
      bhi_q     <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      z0_q      <= '0;
      z2_q      <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (Start) begin
            a_q <= Multiplier;
            b_q <= Multiplicand;
          end
        end
        StLoad: begin
          sign_q <= SIGNED && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          alo_q  <= mag_a[H-1:0];
          ahi_q  <= mag_a[WIDTH-1:H];
          blo_q  <= mag_b[H-1:0];
          bhi_q  <= mag_b[WIDTH-1:H];
          sx_q   <= {1'b0, mag_a[WIDTH-1:H]} + {1'b0, mag_a[H-1:0]};
          sy_q   <= {1'b0, mag_b[WIDTH-1:H]} + {1'b0, mag_b[H-1:0]};
        end
        StMulZ0:   if (sub_done) z0_q <= sub_p;
        StMulZ2:   if (sub_done) z2_q <= sub_p;
        StCombine: product_q <= result;
        default: ;
      endcase
    end
  end

  assign Product = product_q;

  shift_add_mul #(
    .N(N)
  ) u_shift_add_mul (
    .Clock (Clock),
    .Reset (Reset),
    .Start (sub_start),
    .A     (sub_a),
    .B     (sub_b),
    .P     (sub_p),
    .Done  (sub_done)
  );

endmodule

// File: tb/tb_karatsuba_multiplier.sv
// Randomised and directed bench for three karatsuba_multiplier configurations, checked
// against plain integer multiplication.
module tb_karatsuba_multiplier;

  logic clk;
  logic rst_n;

  logic        start0, start1, start2;
  logic [15:0] a0, b0, a1, b1;
  logic [7:0]  a2, b2;
  logic [31:0] p0, p1;
  logic [15:0] p2;
  logic        done0, done1, done2;
  logic        busy0, busy1, busy2;

  int n_checks = 0;
  int n_err    = 0;

  karatsuba_multiplier #(.WIDTH(16), .SIGNED(1'b1)) u_dut_s16 (
    .Clock(clk), .Reset(rst_n), .Start(start0), .Multiplier(a0), .Multiplicand(b0),
    .Product(p0), .Done(done0), .Busy(busy0)
  );

  karatsuba_multiplier #(.WIDTH(16), .SIGNED(1'b0)) u_dut_u16 (
    .Clock(clk), .Reset(rst_n), .Start(start1), .Multiplier(a1), .Multiplicand(b1),
    .Product(p1), .Done(done1), .Busy(busy1)
  );

  karatsuba_multiplier #(.WIDTH(8), .SIGNED(1'b0)) u_dut_u8 (
    .Clock(clk), .Reset(rst_n), .Start(start2), .Multiplier(a2), .Multiplicand(b2),
    .Product(p2), .Done(done2), .Busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the mathematical product, truncated to the configuration's product width.
  function automatic logic [31:0] ref_mul(input int sel, input logic [15:0] a,
                                          input logic [15:0] b);
    longint x, y;
    case (sel)
      0: begin
        x = longint'($signed(a));
        y = longint'($signed(b));
      end
      1: begin
        x = longint'(a);
        y = longint'(b);
      end
      default: begin
        x = longint'(a[7:0]);
        y = longint'(b[7:0]);
      end
    endcase
    ref_mul = (sel == 2) ? {16'h0, 16'(x * y)} : 32'(x * y);
  endfunction

  task automatic drive(input int sel, input logic s, input logic [15:0] a,
                       input logic [15:0] b);
    case (sel)
      0: begin start0 = s; a0 = a; b0 = b; end
      1: begin start1 = s; a1 = a; b1 = b; end
      default: begin start2 = s; a2 = a[7:0]; b2 = b[7:0]; end
    endcase
  endtask

  function automatic logic [31:0] get_p(input int sel);
    return (sel == 0) ? p0 : (sel == 1) ? p1 : {16'h0, p2};
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  endfunction

  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input bit hold);
    int w, lat, cyc;
    logic [31:0] exp;
    w   = (sel == 2) ? 8 : 16;
    lat = 2 + 3 * (w / 2 + 2);
    exp = ref_mul(sel, a, b);
    @(negedge clk);
    drive(sel, 1'b1, a, b);
    @(posedge clk);
    #1;
    check_eq("busy_after_accept", get_busy(sel), 1);
    // Scramble operands right after the accepting edge; they must not matter.
    drive(sel, hold, 16'($urandom), 16'($urandom));
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (get_done(sel)) break;
    end
    check_eq("latency", cyc, lat);
    check_eq("product", get_p(sel), exp);
    check_eq("busy_in_done", get_busy(sel), 0);
    if (hold) begin
      repeat (4) begin
        @(posedge clk);
        #1;
        check_eq("held_start_done", get_done(sel), 1);
        check_eq("held_start_busy", get_busy(sel), 0);
      end
      @(negedge clk);
      drive(sel, 1'b0, a, b);
    end
    @(posedge clk);
    #1;
    check_eq("done_fall", get_done(sel), 0);
    check_eq("product_hold", get_p(sel), exp);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          sel;
    bit          stale;
    rst_n = 1'b0;
    drive(0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 16'h0, 16'h0);
    drive(2, 1'b0, 16'h0, 16'h0);
    #1;
    check_eq("reset_product", {p0, p1}, 64'h0);
    check_eq("reset_done", {done0, done1, done2}, 0);
    check_eq("reset_busy", {busy0, busy1, busy2}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 16'h0003, 16'hFFFC, 1'b0);
    run_op(0, 16'h8000, 16'h8000, 1'b0);
    run_op(0, 16'h8000, 16'h7FFF, 1'b0);
    run_op(1, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op(2, 16'd200, 16'd150, 1'b0);
    run_op(0, 16'h1234, 16'hBEEF, 1'b1);

    for (int i = 0; i < 36; i++) begin
      sel = int'($urandom_range(0, 2));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'h8000;
      if ($urandom_range(0, 7) == 0) rb = 16'hFFFF;
      run_op(sel, ra, rb, ($urandom_range(0, 5) == 0));
    end

    // Reset in the middle of the z2 phase.
    @(negedge clk);
    drive(0, 1'b1, 16'h1234, 16'h0567);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 16'h0, 16'h0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_product", {p0, p1, p2}, 80'h0);
    check_eq("midrst_done", {done0, done1, done2}, 0);
    check_eq("midrst_busy", {busy0, busy1, busy2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done0 || busy0 || (p0 != 32'h0)) stale = 1'b1;
    end
    check_eq("post_reset_idle", stale, 0);
    run_op(0, 16'd7, 16'd9, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
